rv32_regs_mp: RTL and testbench
===============================

// Module: rv32_regs_mp
// PURPOSE
//  Parametrised integer register file for the rv32 pipeline: NRD read ports, NWR write ports, XLEN-bit regs.
//  Read addresses are captured in decode (held on stall); writes are committed from writeback (dropped on flush).
//  Adds optional write->read forwarding and a stall-gated debug access port with a req/ack handshake.
//  Register 0 is hardwired zero.
// PARAMETERS
//  XLEN    32  register width in bits
//  NREGS   32  number of architectural registers (power of 2, >=2); AW = $clog2(NREGS) is a localparam
//  NRD     2   number of read ports
//  NWR     1   number of write ports
// PORTS
//  clk                 in   1         clock, all state on rising edge
//  rst_n               in   1         asynchronous active-low reset
//  stall_in            in   1         hold captured read addresses; enables debug service
//  writeback_flush_in  in   1         suppress all core writes this cycle
//  rs_in               in   NRD*AW    read addresses, port p at [p*AW +: AW]
//  rs_value_out        out  NRD*XLEN  read data, port p at [p*XLEN +: XLEN]
//  rd_in               in   NWR*AW    write addresses
//  rd_write_in         in   NWR       per-port write enable
//  rd_value_in         in   NWR*XLEN  write data
//  dbg_req             in   1         debug request; held high until dbg_ack
//  dbg_we              in   1         1 = write, 0 = read (sampled with dbg_req)
//  dbg_addr            in   AW        debug register index
//  dbg_wdata           in   XLEN      debug write data
//  dbg_ack             out  1         one-cycle pulse: request completed
//  dbg_rdata           out  XLEN      debug read data, valid while dbg_ack=1
// BEHAVIOUR
//  Reset (async, rst_n=0): all regs=0, captured addresses=0, dbg_ack=0, dbg_rdata=0 => every rs_value_out=0.
//  Address capture: on posedge with stall_in=0, rs_q[p]<=rs_in[p]; stall_in=1 holds rs_q.
//  Read: rs_value_out[p] = regs[rs_q[p]] combinationally. Index 0 always reads 0.
//  Core write: port k is effective iff rd_write_in[k] & !writeback_flush_in & rd_in[k]!=0.
//    Effective writes commit on the next posedge. Same rd on several ports: highest port index wins.
//  Debug FSM: IDLE -> (dbg_req & stall_in & no effective core write) -> ACK -> IDLE.
//    Accept edge: write does regs[dbg_addr]<=dbg_wdata (index 0 ignored);
//      read does dbg_rdata<=regs[dbg_addr] (pre-write value).
//    ACK: dbg_ack=1 for exactly one cycle; dbg_rdata is held until the next accept.
//    While stall_in=0 or a core write is effective, the request waits in IDLE. No timeout.
//    Back-to-back requests: the next request is accepted no earlier than the cycle after ACK.
//  Reset mid-operation: FSM returns to IDLE and the pending ack is lost; the requester reissues.
//  Out-of-range indices cannot occur (NREGS a power of 2).
// CONFIGURATION
//  RV32_REGS_BYPASS_EN defined: if an effective core write this cycle targets rs_q[p]!=0,
//    rs_value_out[p] returns that write data (highest port index wins) -- same-cycle forwarding.
//  Undefined: rs_value_out reflects only committed state; a new value is visible the cycle after the write edge.
//  Debug writes are never forwarded, in either build.
// STRUCTURE
//  Package rv32_regs_pkg: XLEN default, reg_idx_t typedef, ZERO_REG constant, dbg_state_e enum {IDLE, ACK}.
//  Sub-module rv32_regs_wr_arb: per-register write-select and data mux from NWR ports with
//    highest-index priority. It is shared by the commit path and the bypass path.
//  Top level: register array, rs_q capture, read muxes, debug FSM.
// TESTING
//  1. rst_n=0 mid-run after regs written -> all rs_value_out=0 and dbg_ack=0 immediately (async).
//  2. Write x5=0xDEADBEEF, rs_in[0]=5 -> reads 0xDEADBEEF the cycle after commit; write to x0 -> x0 still reads 0.
//  3. NWR=2, both ports write x7 (0x11 on port 0, 0x22 on port 1) -> x7=0x22; same with flush=1 -> x7 unchanged.
//  4. Capture rs_in=3, raise stall_in, change rs_in=9 -> output still tracks x3 until stall drops.
//  5. BYPASS_EN: rs_q=4 with a same-cycle write x4=0xA5 -> 0xA5 that cycle; without the macro -> old value, then 0xA5.
//  6. dbg read x5 with stall_in=0 -> no ack; raise stall_in -> dbg_ack 1 cycle later, dbg_rdata=0xDEADBEEF;
//     dbg write x0 -> acked, x0 stays 0.

Source files
------------

// File: rtl/rv32_regs_pkg.sv
// Shared types and constants for the rv32 multi-port integer register file.
package rv32_regs_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  // Register index for the default-sized register file.
  typedef logic [AW_DEF-1:0] reg_idx_t;

  // x0 is hardwired to zero: never written, always reads zero.
  localparam int ZERO_REG = 0;

  // Debug access handshake: wait for a quiet stalled cycle, then pulse ack once.
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } dbg_state_e;

endpackage

// File: rtl/rv32_regs_mp_if.sv
// Debug access port of the register file: req/ack handshake with read/write data.
interface rv32_regs_mp_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);

  logic            dbg_req;
  logic            dbg_we;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_wdata;
  logic            dbg_ack;
  logic [XLEN-1:0] dbg_rdata;

  // Requester side (debugger).
  modport master (
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata
  );

  // Register file side.
  modport slave (
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata
  );

endinterface

// File: rtl/rv32_regs_wr_arb.sv
// Per-register write select and data mux from the NWR core write ports.
// A port is effective only when enabled, not flushed and not targeting x0;
// when several ports hit the same register the highest port index wins.
// Shared by the commit path and the same-cycle forwarding path.
module rv32_regs_wr_arb
  import rv32_regs_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NWR   = 1,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                flush_i,
  input  logic [NWR*AW-1:0]   rd_i,
  input  logic [NWR-1:0]      we_i,
  input  logic [NWR*XLEN-1:0] data_i,
  output logic [NREGS-1:0]    sel_o,
  output logic [XLEN-1:0]     data_o [NREGS],
  output logic                any_o
);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic            sel_l;
      logic [XLEN-1:0] data_l;

      // Scan ports in ascending order so a later (higher) port overrides.
      always_comb begin
        sel_l  = 1'b0;
        data_l = '0;
        for (int k = 0; k < NWR; k++) begin
          if (we_i[k] && !flush_i && (gi != ZERO_REG) &&
              (rd_i[k*AW +: AW] == AW'(gi))) begin
            sel_l  = 1'b1;
            data_l = data_i[k*XLEN +: XLEN];
          end
        end
      end

      assign sel_o[gi]  = sel_l;
      assign data_o[gi] = data_l;
    end
  endgenerate

  assign any_o = |sel_o;

endmodule

// File: rtl/rv32_regs_mp.sv
// rv32 integer register file: NRD read ports with decode-time address capture,
// NWR writeback ports, x0 hardwired to zero, and a stall-gated debug port.
// Optional feature macro RV32_REGS_BYPASS_EN: forwards an effective core write
// to a read port whose captured address matches, in the same cycle.
module rv32_regs_mp
  import rv32_regs_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_in,
  input  logic                writeback_flush_in,
  input  logic [NRD*AW-1:0]   rs_in,
  output logic [NRD*XLEN-1:0] rs_value_out,
  input  logic [NWR*AW-1:0]   rd_in,
  input  logic [NWR-1:0]      rd_write_in,
  input  logic [NWR*XLEN-1:0] rd_value_in,
  rv32_regs_mp_if.slave       dbg
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NRD*AW-1:0] rs_q;
  logic [XLEN-1:0] dbg_rdata_q;
  logic [XLEN-1:0] dbg_rd_val;
  dbg_state_e      state_q, state_d;
  logic            dbg_accept;

  logic [NREGS-1:0] arb_sel;
  logic [XLEN-1:0]  arb_data [NREGS];
  logic             core_wr_any;

  rv32_regs_wr_arb #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_wr_arb (
    .flush_i (writeback_flush_in),
    .rd_i    (rd_in),
    .we_i    (rd_write_in),
    .data_i  (rd_value_in),
    .sel_o   (arb_sel),
    .data_o  (arb_data),
    .any_o   (core_wr_any)
  );

  // Next register contents: core writes, or a debug write on its accept edge.
  // The FSM only accepts when no core write is effective, so they never collide.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (arb_sel[i]) begin
        regs_d[i] = arb_data[i];
      end else if (dbg_accept && dbg.dbg_we && (i != ZERO_REG) &&
                   (dbg.dbg_addr == AW'(i))) begin
        regs_d[i] = dbg.dbg_wdata;
      end
    end
  end

  // Register array state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Capture read addresses in decode; a stall holds them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q <= '0;
    end else if (!stall_in) begin
      rs_q <= rs_in;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   idx;
      logic [XLEN-1:0] committed;
      assign idx       = rs_q[gi*AW +: AW];
      assign committed = (idx == AW'(ZERO_REG)) ? '0 : regs_q[idx];
`ifdef RV32_REGS_BYPASS_EN
      // arb_sel is never set for x0, so forwarding cannot leak into x0.
      assign rs_value_out[gi*XLEN +: XLEN] = arb_sel[idx] ? arb_data[idx] : committed;
`else
      assign rs_value_out[gi*XLEN +: XLEN] = committed;
`endif
    end
  endgenerate

  assign dbg_rd_val = (dbg.dbg_addr == AW'(ZERO_REG)) ? '0 : regs_q[dbg.dbg_addr];

  // Debug FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Debug FSM next state: accept only while stalled and no core write is effective.
  always_comb begin
    state_d    = state_q;
    dbg_accept = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dbg.dbg_req && stall_in && !core_wr_any) begin
          dbg_accept = 1'b1;
          state_d    = ACK;
        end
      end
      ACK: state_d = IDLE;
    endcase
  end

  // Debug read data: pre-write value sampled on a read accept, then held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_rdata_q <= '0;
    end else if (dbg_accept && !dbg.dbg_we) begin
      dbg_rdata_q <= dbg_rd_val;
    end
  end

  assign dbg.dbg_ack   = (state_q == ACK);
  assign dbg.dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_rv32_regs_mp.sv
// Scoreboard bench for rv32_regs_mp (NRD=2, NWR=2): the stimulus pushes expected
// read/ack values; a negedge monitor pops and compares them.
module tb_rv32_regs_mp;
  import rv32_regs_pkg::*;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  localparam int K_RS0   = 0;
  localparam int K_RS1   = 1;
  localparam int K_ACK   = 2;
  localparam int K_RDATA = 3;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } out_exp_t;

  typedef struct {
    int          cyc;
    bit          chk;
    logic [31:0] val;
    string       name;
  } dbg_exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                stall_in;
  logic                writeback_flush_in;
  logic [NRD*AW-1:0]   rs_in;
  logic [NRD*XLEN-1:0] rs_value_out;
  logic [NWR*AW-1:0]   rd_in;
  logic [NWR-1:0]      rd_write_in;
  logic [NWR*XLEN-1:0] rd_value_in;

  rv32_regs_mp_if #(.XLEN(XLEN), .AW(AW)) dbg ();

  rv32_regs_mp #(
    .XLEN  (XLEN),
    .NREGS (32),
    .NRD   (NRD),
    .NWR   (NWR)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stall_in           (stall_in),
    .writeback_flush_in (writeback_flush_in),
    .rs_in              (rs_in),
    .rs_value_out       (rs_value_out),
    .rd_in              (rd_in),
    .rd_write_in        (rd_write_in),
    .rd_value_in        (rd_value_in),
    .dbg                (dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  out_exp_t out_q[$];
  dbg_exp_t dbg_q[$];

  out_exp_t    oe;
  dbg_exp_t    de;
  logic [31:0] act;

  // Monitor: compare queued output expectations and every debug ack.
  always @(negedge clk) begin
    while (out_q.size() > 0 && out_q[0].cyc <= cyc) begin
      oe = out_q.pop_front();
      case (oe.kind)
        K_RS0:   act = rs_value_out[31:0];
        K_RS1:   act = rs_value_out[63:32];
        K_ACK:   act = {31'b0, dbg.dbg_ack};
        default: act = dbg.dbg_rdata;
      endcase
      checks++;
      if (oe.cyc != cyc || act !== oe.val) begin
        fails++;
        $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
                 oe.name, act, cyc, oe.val, oe.cyc);
      end else begin
        $display("ok   %s: %h (cycle %0d)", oe.name, act, cyc);
      end
    end
    if (dbg.dbg_ack === 1'b1) begin
      checks++;
      if (dbg_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack: got dbg_ack=1 at cycle %0d, expected no ack", cyc);
      end else begin
        de = dbg_q.pop_front();
        if (de.cyc != cyc) begin
          fails++;
          $display("FAIL %s_cycle: got ack at cycle %0d, expected cycle %0d", de.name, cyc, de.cyc);
        end else begin
          $display("ok   %s_cycle: ack at cycle %0d", de.name, cyc);
        end
        if (de.chk) begin
          checks++;
          if (dbg.dbg_rdata !== de.val) begin
            fails++;
            $display("FAIL %s_rdata: got %h, expected %h", de.name, dbg.dbg_rdata, de.val);
          end else begin
            $display("ok   %s_rdata: %h", de.name, dbg.dbg_rdata);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_out(int kind, logic [31:0] v, string nm);
    out_exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.val  = v;
    e.name = nm;
    out_q.push_back(e);
  endtask

  task automatic push_dbg(int c, bit chk, logic [31:0] v, string nm);
    dbg_exp_t e;
    e.cyc  = c;
    e.chk  = chk;
    e.val  = v;
    e.name = nm;
    dbg_q.push_back(e);
  endtask

  task automatic set_rs(int p, int a);
    rs_in[p*AW +: AW] = AW'(a);
  endtask

  task automatic wr(int p, int a, logic [31:0] v);
    rd_in[p*AW +: AW]         = AW'(a);
    rd_value_in[p*XLEN +: XLEN] = v;
    rd_write_in[p]            = 1'b1;
  endtask

  task automatic clr_wr();
    rd_write_in = '0;
  endtask

  task automatic dbg_issue(bit we, int a, logic [31:0] wd);
    dbg.dbg_req   = 1'b1;
    dbg.dbg_we    = we;
    dbg.dbg_addr  = reg_idx_t'(a);
    dbg.dbg_wdata = wd;
  endtask

  // Bounded wait for the ack pulse; returns in the ack cycle with req dropped.
  task automatic wait_ack(string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dbg.dbg_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: got no dbg_ack in 10 cycles, expected an ack", nm);
    end
    dbg.dbg_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; stall_in = 1'b0; writeback_flush_in = 1'b0;
    rs_in = '0; rd_in = '0; rd_write_in = '0; rd_value_in = '0;
    dbg.dbg_req = 1'b0; dbg.dbg_we = 1'b0; dbg.dbg_addr = '0; dbg.dbg_wdata = '0;

    step();
    exp_out(K_RS0, 32'h0, "reset_rs0");
    exp_out(K_RS1, 32'h0, "reset_rs1");
    exp_out(K_ACK, 32'h0, "reset_ack");
    rst_n = 1'b1;

    // Basic write/read, x0 write ignored.
    step();
    set_rs(0, 5); set_rs(1, 0); wr(0, 5, 32'hDEADBEEF);
    step();
    clr_wr(); exp_out(K_RS0, 32'hDEADBEEF, "x5_read"); wr(0, 0, 32'h12345678);
    step();
    clr_wr(); exp_out(K_RS1, 32'h0, "x0_zero"); exp_out(K_RS0, 32'hDEADBEEF, "x5_keep");

    // Two ports to x7: port 1 wins; flushed writes dropped.
    set_rs(0, 7); wr(0, 7, 32'h11); wr(1, 7, 32'h22);
    step();
    clr_wr(); exp_out(K_RS0, 32'h22, "x7_prio");
    wr(0, 7, 32'h33); wr(1, 7, 32'h44); writeback_flush_in = 1'b1;
    step();
    clr_wr(); writeback_flush_in = 1'b0; exp_out(K_RS0, 32'h22, "x7_flush");

    // Stall holds captured address.
    set_rs(0, 3); wr(0, 3, 32'h333); wr(1, 9, 32'h999);
    step();
    clr_wr(); exp_out(K_RS0, 32'h333, "x3_read"); stall_in = 1'b1; set_rs(0, 9);
    step();
    exp_out(K_RS0, 32'h333, "stall_hold1");
    step();
    exp_out(K_RS0, 32'h333, "stall_hold2"); stall_in = 1'b0;
    step();
    exp_out(K_RS0, 32'h999, "stall_release"); set_rs(0, 4);

    // Same-cycle write to the captured address.
    step();
    wr(0, 4, 32'hA5);
`ifdef RV32_REGS_BYPASS_EN
    exp_out(K_RS0, 32'hA5, "bypass_same");
`else
    exp_out(K_RS0, 32'h0, "bypass_same");
`endif
    step();
    clr_wr(); exp_out(K_RS0, 32'hA5, "x4_after");

    // Debug read waits for stall.
    dbg_issue(1'b0, 5, 32'h0);
    repeat (3) begin
      step();
      exp_out(K_ACK, 32'h0, "dbg_wait_nostall");
    end
    stall_in = 1'b1;
    push_dbg(cyc + 1, 1'b1, 32'hDEADBEEF, "dbg_rd_x5");
    wait_ack("dbg_rd_x5");

    // Debug write waits for an effective core write to clear.
    wr(0, 2, 32'h22); dbg_issue(1'b1, 6, 32'h66);
    repeat (2) begin
      step();
      exp_out(K_ACK, 32'h0, "dbg_wait_corewr");
    end
    clr_wr();
    push_dbg(cyc + 1, 1'b0, 32'h0, "dbg_wr_x6");
    wait_ack("dbg_wr_x6");
    stall_in = 1'b0; set_rs(0, 2); set_rs(1, 6);
    step();
    exp_out(K_RS0, 32'h22, "x2_core"); exp_out(K_RS1, 32'h66, "x6_dbg");
    exp_out(K_RDATA, 32'hDEADBEEF, "rdata_held");

    // Debug write to x0, then back-to-back debug read of x0.
    stall_in = 1'b1; dbg_issue(1'b1, 0, 32'hFFFFFFFF);
    push_dbg(cyc + 1, 1'b0, 32'h0, "dbg_wr_x0");
    wait_ack("dbg_wr_x0");
    dbg_issue(1'b0, 0, 32'h0);
    push_dbg(cyc + 2, 1'b1, 32'h0, "dbg_rd_x0");
    wait_ack("dbg_rd_x0");

    // Asynchronous reset during the ack cycle.
    stall_in = 1'b0; set_rs(0, 5); set_rs(1, 6);
    step();
    stall_in = 1'b1; dbg_issue(1'b0, 5, 32'h0);
    step();
    rst_n = 1'b0;
    exp_out(K_RS0, 32'h0, "amid_reset_rs0");
    exp_out(K_RS1, 32'h0, "amid_reset_rs1");
    exp_out(K_ACK, 32'h0, "amid_reset_ack");
    exp_out(K_RDATA, 32'h0, "amid_reset_rdata");
    dbg.dbg_req = 1'b0;
    step();
    exp_out(K_ACK, 32'h0, "reset_held_ack");
    rst_n = 1'b1; stall_in = 1'b0;
    step();
    exp_out(K_RS0, 32'h0, "x5_cleared"); exp_out(K_RS1, 32'h0, "x6_cleared");
    stall_in = 1'b1; dbg_issue(1'b0, 5, 32'h0);
    push_dbg(cyc + 1, 1'b1, 32'h0, "dbg_rd_x5_reset");
    wait_ack("dbg_rd_x5_reset");

    step();
    step();
    checks++;
    if (out_q.size() != 0 || dbg_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d output and %0d ack expectations left, expected 0 and 0",
               out_q.size(), dbg_q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
